fg_button_ctrl: RTL and testbench
=================================

# fg_button_ctrl

Front-panel controller for the function generator. Samples the raw up, down and mode push-buttons on a slow tick and turns each press into a single clean event. Arbitrates events that arrive together and runs a small edit-mode state machine. Holds the waveform, frequency-index and amplitude-index registers that drive the waveform datapath.

## Interface
Parameters:
- FREQ_W, 8, width of freq_idx
- FREQ_MAX, 199, highest legal freq_idx
- AMP_W, 4, width of amp_idx
- AMP_MAX, 15, highest legal amp_idx; also the reset value of amp_idx
- REPEAT_DELAY, 4, ticks a button is held before the first auto-repeat
- REPEAT_RATE, 1, ticks between subsequent auto-repeats (1..REPEAT_DELAY)

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-high; clears all state immediately
- tick, in, 1, one-clk sample enable (nominally 4 Hz)
- btn_up, in, 1, raw button level
- btn_down, in, 1, raw button level
- btn_mode, in, 1, raw button level
- edit_state, out, 2, 00 WAVE, 01 FREQ, 10 AMP
- wave_sel, out, 2, selected waveform
- freq_idx, out, FREQ_W, frequency table index
- amp_idx, out, AMP_W, amplitude index
- cfg_update, out, 1, one-clk pulse when wave_sel, freq_idx or amp_idx changes

## Operation
- Sampler per button: two flops, s1 then s2. Both load only on clk edges where tick=1: s1 takes the button, s2 takes s1.
- Press event: on a tick edge where s1 rises with s2=0, the block registers a 1-clk event pulse.
- Auto-repeat applies to up and down only.
  - A per-button hold counter, width clog2(REPEAT_DELAY+1), is cleared whenever s1 & s2 is 0.
  - On each tick edge where the button stays held, the counter increments.
  - When the counter reaches REPEAT_DELAY, a repeat event is issued and the counter reloads REPEAT_DELAY-REPEAT_RATE.
- Arbitration among same-cycle events:
  - mode has priority over up and down; any up/down in that cycle is dropped.
  - up and down together without mode: both are dropped.
- Edit FSM:
  - States are WAVE, FREQ and AMP. A mode event steps WAVE→FREQ→AMP→WAVE.
  - No other transitions. edit_state is the registered state code.
- Up/down actions by state:
  - WAVE: wave_sel ±1, wrapping 3↔0.
  - FREQ: freq_idx ±1, saturating at 0 and FREQ_MAX.
  - AMP: amp_idx ±1, saturating at 0 and AMP_MAX.
- cfg_update is asserted only when a value actually changes. A saturated press and a mode event give no pulse.
- Reset values: edit_state=WAVE, wave_sel=0, freq_idx=0, amp_idx=AMP_MAX, cfg_update=0, sampler flops=0, hold counters=0.
- Reset while a button is held: after release of reset, the held level counts as a new press at the first tick, because s2 is 0.

## Timing
- Let tick edge T be the edge where s1 first captures 1.
  - The event pulse is high in the clk cycle after T.
  - The value register and cfg_update are updated at edge T+1 clk. cfg_update is high for exactly that one cycle.
- Edit-state change appears at edge T+1 clk.
- First repeat: REPEAT_DELAY ticks after the press tick. Then one repeat every REPEAT_RATE ticks while held.
- Release: no event. The hold counter clears at the tick edge where s1 samples 0.
- Presses shorter than one tick period may be missed; this is by design (tick-rate debouncing).
- At most one value change per clk cycle.

## Test plan
- Reset: assert reset mid-frame → outputs go to 00/0/0/15/0 immediately, without waiting for a clk edge.
- Wave wrap: in WAVE, give 4 up presses → wave_sel 1,2,3,0 with 4 cfg_update pulses. Then 1 down → 3.
- Freq saturation: mode ×1 (FREQ), then 1 down → freq_idx stays 0 with no cfg_update. Hold up for 4+10 ticks (REPEAT_DELAY=4, RATE=1) → freq_idx=11 (1 press + 10 repeats). The first repeat lands exactly 4 ticks after the press.
- Amp: mode ×2 (AMP), 1 up → no change and no pulse (already 15). 3 downs → 12.
- Simultaneous: press up+down on the same tick → no change. Press mode+up on the same tick → edit_state advances and the value is unchanged.
- Glitch: raise btn_up for less than one tick period, between ticks → no event, no cfg_update.

Source files
------------

// File: rtl/fg_button_ctrl_if.sv
// Front-panel bus: sample tick, raw button levels and the configuration registers
// the controller presents to the waveform datapath.
interface fg_button_ctrl_if #(
  parameter int unsigned FREQ_W = 8,
  parameter int unsigned AMP_W  = 4
);
  logic              tick;
  logic              btn_up;
  logic              btn_down;
  logic              btn_mode;
  logic [1:0]        edit_state;
  logic [1:0]        wave_sel;
  logic [FREQ_W-1:0] freq_idx;
  logic [AMP_W-1:0]  amp_idx;
  logic              cfg_update;

  modport master (
    output tick, btn_up, btn_down, btn_mode,
    input  edit_state, wave_sel, freq_idx, amp_idx, cfg_update
  );

  modport slave (
    input  tick, btn_up, btn_down, btn_mode,
    output edit_state, wave_sel, freq_idx, amp_idx, cfg_update
  );
endinterface

// File: rtl/fg_button_ctrl.sv
// Function-generator front panel: tick-rate button sampling, press/auto-repeat events,
// event arbitration, edit-mode FSM and the wave/freq/amp configuration registers.
module fg_button_ctrl #(
  parameter int unsigned FREQ_W       = 8,
  parameter int unsigned FREQ_MAX     = 199,
  parameter int unsigned AMP_W        = 4,
  parameter int unsigned AMP_MAX      = 15,
  parameter int unsigned REPEAT_DELAY = 4,
  parameter int unsigned REPEAT_RATE  = 1
) (
  input logic             clk,
  input logic             reset,
  fg_button_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {
    WAVE = 2'b00,
    FREQ = 2'b01,
    AMP  = 2'b10
  } state_t;

  // Button vector order: [0] up, [1] down, [2] mode
  logic [2:0]       btn;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic             tick_d;
  logic [2:0]       press_c;
  logic [1:0]       rep_ev;
  logic [CNT_W-1:0] hold_cnt [2];
  logic             ev_up_c;
  logic             ev_down_c;
  logic             ev_mode_c;

  state_t            state;
  logic [1:0]        wave_q;
  logic [FREQ_W-1:0] freq_q;
  logic [AMP_W-1:0]  amp_q;
  logic              cfg_q;

  assign btn = {bus.btn_mode, bus.btn_down, bus.btn_up};

  // Two-stage tick-rate sampler; tick_d marks the clk cycle right after a tick edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= bus.tick;
      if (bus.tick) begin
        s1 <= btn;
        s2 <= s1;
      end
    end
  end

  // A fresh rising sample is visible for exactly one clk after its tick edge
  assign press_c = {3{tick_d}} & s1 & ~s2;

  // Auto-repeat counters for up/down; reload keeps REPEAT_RATE spacing after the first repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt[0] <= '0;
      hold_cnt[1] <= '0;
      rep_ev      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_ev[i] <= 1'b0;
        if (bus.tick && btn[i] && s1[i]) begin
          if (hold_cnt[i] == CNT_W'(REPEAT_DELAY - 1)) begin
            rep_ev[i]   <= 1'b1;
            hold_cnt[i] <= CNT_W'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
          end
        end else if (bus.tick || !(s1[i] && s2[i])) begin
          hold_cnt[i] <= '0;
        end
      end
    end
  end

  assign ev_up_c   = press_c[0] | rep_ev[0];
  assign ev_down_c = press_c[1] | rep_ev[1];
  assign ev_mode_c = press_c[2];

  // Edit FSM and value registers; mode beats up/down, up+down together cancel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WAVE;
      wave_q <= 2'd0;
      freq_q <= '0;
      amp_q  <= AMP_W'(AMP_MAX);
      cfg_q  <= 1'b0;
    end else begin
      cfg_q <= 1'b0;
      if (ev_mode_c) begin
        case (state)
          WAVE:    state <= FREQ;
          FREQ:    state <= AMP;
          default: state <= WAVE;
        endcase
      end else if (ev_up_c ^ ev_down_c) begin
        case (state)
          WAVE: begin
            wave_q <= ev_up_c ? wave_q + 2'd1 : wave_q - 2'd1;
            cfg_q  <= 1'b1;
          end
          FREQ: begin
            if (ev_up_c && freq_q != FREQ_W'(FREQ_MAX)) begin
              freq_q <= freq_q + FREQ_W'(1);
              cfg_q  <= 1'b1;
            end else if (ev_down_c && freq_q != '0) begin
              freq_q <= freq_q - FREQ_W'(1);
              cfg_q  <= 1'b1;
            end
          end
          default: begin
            if (ev_up_c && amp_q != AMP_W'(AMP_MAX)) begin
              amp_q <= amp_q + AMP_W'(1);
              cfg_q <= 1'b1;
            end else if (ev_down_c && amp_q != '0) begin
              amp_q <= amp_q - AMP_W'(1);
              cfg_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.edit_state = state;
  assign bus.wave_sel   = wave_q;
  assign bus.freq_idx   = freq_q;
  assign bus.amp_idx    = amp_q;
  assign bus.cfg_update = cfg_q;

endmodule

// File: tb/tb_fg_button_ctrl.sv
// Scoreboard bench for fg_button_ctrl: a behavioural panel model queues every expected
// configuration change; a negedge monitor pops one entry per cfg_update pulse.
module tb_fg_button_ctrl;

  localparam int unsigned TP           = 8;
  localparam int unsigned REPEAT_DELAY = 4;
  localparam int unsigned REPEAT_RATE  = 1;
  localparam int unsigned FREQ_MAX     = 199;
  localparam int unsigned AMP_MAX      = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fg_button_ctrl_if #(.FREQ_W(8), .AMP_W(4)) ifc ();

  fg_button_ctrl #(
    .FREQ_W(8), .FREQ_MAX(FREQ_MAX), .AMP_W(4), .AMP_MAX(AMP_MAX),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  typedef struct {
    int unsigned wave;
    int unsigned freq;
    int unsigned amp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned upd_cyc[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned m_state, m_wave, m_freq, m_amp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Free-running sample tick, one clk wide every TP clocks
  initial begin
    ifc.tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ifc.tick = (cyc % TP == 0);
    end
  end

  always @(negedge clk) begin
    if (!reset && ifc.cfg_update) begin
      upd_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_cfg_update", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("upd.wave_sel", 32'(ifc.wave_sel), mon_e.wave);
        check("upd.freq_idx", 32'(ifc.freq_idx), mon_e.freq);
        check("upd.amp_idx",  32'(ifc.amp_idx),  mon_e.amp);
      end
    end
  end

  // One arbitrated event applied to the panel model
  function automatic void apply(input bit u, input bit d, input bit m);
    bit changed = 1'b0;
    if (m) begin
      m_state = (m_state == 2) ? 0 : m_state + 1;
    end else if (u ^ d) begin
      case (m_state)
        0: begin m_wave = u ? (m_wave + 1) % 4 : (m_wave + 3) % 4; changed = 1'b1; end
        1: begin
          if (u && m_freq < FREQ_MAX) begin m_freq++; changed = 1'b1; end
          else if (d && m_freq > 0)   begin m_freq--; changed = 1'b1; end
        end
        default: begin
          if (u && m_amp < AMP_MAX) begin m_amp++; changed = 1'b1; end
          else if (d && m_amp > 0)  begin m_amp--; changed = 1'b1; end
        end
      endcase
    end
    if (changed) sb.push_back('{m_wave, m_freq, m_amp});
  endfunction

  task automatic wait_tick();
    do @(posedge clk); while (!ifc.tick);
  endtask

  // Hold the given buttons across nt tick samples, then release and let things settle
  task automatic press(input bit u, input bit d, input bit m, input int unsigned nt);
    bit rep;
    wait_tick();
    @(negedge clk);
    ifc.btn_up = u; ifc.btn_down = d; ifc.btn_mode = m;
    for (int unsigned k = 0; k < nt; k++) begin
      rep = (k >= REPEAT_DELAY) && ((k - REPEAT_DELAY) % REPEAT_RATE == 0);
      apply(u && (k == 0 || rep), d && (k == 0 || rep), m && (k == 0));
      wait_tick();
    end
    @(negedge clk);
    ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_mode = 1'b0;
    wait_tick();
    wait_tick();
    repeat (3) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, ".edit_state"}, 32'(ifc.edit_state), m_state);
    check({tag, ".wave_sel"},   32'(ifc.wave_sel),   m_wave);
    check({tag, ".freq_idx"},   32'(ifc.freq_idx),   m_freq);
    check({tag, ".amp_idx"},    32'(ifc.amp_idx),    m_amp);
    check({tag, ".pending"},    32'(sb.size()),      32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".edit_state"}, 32'(ifc.edit_state), 32'd0);
    check({tag, ".wave_sel"},   32'(ifc.wave_sel),   32'd0);
    check({tag, ".freq_idx"},   32'(ifc.freq_idx),   32'd0);
    check({tag, ".amp_idx"},    32'(ifc.amp_idx),    32'd15);
    check({tag, ".cfg_update"}, 32'(ifc.cfg_update), 32'd0);
  endtask

  initial begin
    ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_mode = 1'b0;
    m_state = 0; m_wave = 0; m_freq = 0; m_amp = AMP_MAX;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // WAVE: four ups wrap 1,2,3,0 then one down to 3
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b1, 1'b0, 1);
    checkpoint("wave");

    // FREQ: down saturates at 0, then held up gives press + 10 repeats
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b0, 1'b1, 1'b0, 1);
    checkpoint("freq_sat");
    upd_cyc.delete();
    press(1'b1, 1'b0, 1'b0, REPEAT_DELAY + 10);
    checkpoint("freq_hold");
    check("freq_hold.n_updates", 32'(upd_cyc.size()), 32'd11);
    if (upd_cyc.size() >= 3) begin
      check("first_repeat_gap", upd_cyc[1] - upd_cyc[0], REPEAT_DELAY * TP);
      check("repeat_rate_gap",  upd_cyc[2] - upd_cyc[1], REPEAT_RATE * TP);
    end

    // AMP: up saturated at 15, then three downs
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1'b0, 1);
    checkpoint("amp_sat");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 1);
    checkpoint("amp_down");

    // Simultaneous events
    press(1'b1, 1'b1, 1'b0, 1);
    checkpoint("up_down");
    press(1'b1, 1'b0, 1'b1, 1);
    checkpoint("mode_up");

    // Glitch between ticks is never sampled
    wait_tick();
    repeat (2) @(negedge clk);
    ifc.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    ifc.btn_up = 1'b0;
    wait_tick();
    wait_tick();
    repeat (3) @(negedge clk);
    checkpoint("glitch");

    // Asynchronous reset takes effect before any clk edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    m_state = 0; m_wave = 0; m_freq = 0; m_amp = AMP_MAX;

    // Button held through reset counts as a fresh press at the first tick
    ifc.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 1'b0, 1'b0);
    wait_tick();
    @(negedge clk);
    ifc.btn_up = 1'b0;
    wait_tick();
    wait_tick();
    repeat (3) @(negedge clk);
    checkpoint("held_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
